// File: rtl/des_ip_stage.sv
// DES initial-permutation stage: one 64-bit block per cycle, registered halves
// with one-cycle latency, ahead of the Feistel rounds.
module des_ip_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic [31:0] left_data_out,
  output logic [31:0] right_data_out,
  output logic        data_out_valid
);

  localparam int unsigned BLOCK_W = 64;
  localparam int unsigned HALF_W  = 32;

  // IP[i] for i = 1..64: rows 1-4 start at 58,60,62,64, rows 5-8 at 57,59,61,63,
  // and each step along a row subtracts 8.
  function automatic int unsigned ip_idx(input int unsigned i);
    int unsigned r;
    int unsigned c;
    r = (i - 1) / 8;
    c = (i - 1) % 8;
    if (r < 4) ip_idx = 58 + 2 * r - 8 * c;
    else       ip_idx = 57 + 2 * (r - 4) - 8 * c;
  endfunction

  // P[i] lands at perm[64-i]; DES bit k of the input is data_in[64-k].
  logic [BLOCK_W-1:0] perm;

  for (genvar i = 1; i <= 64; i++) begin : g_ip
    assign perm[BLOCK_W-i] = data_in[BLOCK_W-ip_idx(i)];
  end

  // P[1..32] (DES L0) goes to the right half, P[33..64] (DES R0) to the left.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      left_data_out  <= '0;
      right_data_out <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= data_in_valid;
      if (data_in_valid) begin
        right_data_out <= perm[BLOCK_W-1:HALF_W];
        left_data_out  <= perm[HALF_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_des_ip_stage.sv
// Directed bench for des_ip_stage: reset, single blocks, back-to-back blocks,
// hold behaviour and mid-flight reset against hand-computed results.
module tb_des_ip_stage;

  logic        clk_in;
  logic        rst_in;
  logic [63:0] data_in;
  logic        data_in_valid;
  logic [31:0] left_data_out;
  logic [31:0] right_data_out;
  logic        data_out_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IN_A  = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] IN_B  = 64'h73117F0B979D4E4E;
  localparam logic [63:0] IN_C  = 64'hF287A22A497586D0;
  localparam logic [31:0] L_A   = 32'hFFFFFFFF;
  localparam logic [31:0] R_A   = 32'h00000000;
  localparam logic [31:0] L_B   = 32'h3005ECDD;
  localparam logic [31:0] R_B   = 32'hC537F43F;
  localparam logic [31:0] L_C   = 32'hC72D184F;
  localparam logic [31:0] R_C   = 32'hB1A16232;

  des_ip_stage dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .left_data_out (left_data_out),
    .right_data_out(right_data_out),
    .data_out_valid(data_out_valid)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Compares {valid, left, right} against the expected triple.
  task automatic chk(input string tag, input logic exp_v, input logic [31:0] exp_l,
                     input logic [31:0] exp_r);
    logic [64:0] obs;
    logic [64:0] exp;
    obs = {data_out_valid, left_data_out, right_data_out};
    exp = {exp_v, exp_l, exp_r};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed v=%b l=%h r=%h expected v=%b l=%h r=%h", tag,
             obs[64], obs[63:32], obs[31:0], exp[64], exp[63:32], exp[31:0]);
    end
  endtask

  initial begin
    rst_in        = 1'b1;
    data_in       = IN_A;
    data_in_valid = 1'b1;

    // Reset held with valid input present
    #1;
    chk("reset_t0", 1'b0, 32'h0, 32'h0);
    @(posedge clk_in); #1;
    chk("reset_edge1", 1'b0, 32'h0, 32'h0);
    @(posedge clk_in); #1;
    chk("reset_edge2", 1'b0, 32'h0, 32'h0);

    // Release reset; X data with valid low must be ignored
    @(negedge clk_in);
    rst_in        = 1'b0;
    data_in_valid = 1'b0;
    data_in       = 'x;
    @(posedge clk_in); #1;
    chk("idle_x_ignored", 1'b0, 32'h0, 32'h0);

    // Single block A
    @(negedge clk_in);
    data_in = IN_A; data_in_valid = 1'b1;
    @(posedge clk_in); #1;
    chk("single_a", 1'b1, L_A, R_A);
    @(negedge clk_in);
    data_in = 'x; data_in_valid = 1'b0;
    @(posedge clk_in); #1;
    chk("single_a_strobe_end", 1'b0, L_A, R_A);

    // Single block B
    @(negedge clk_in);
    data_in = IN_B; data_in_valid = 1'b1;
    @(posedge clk_in); #1;
    chk("single_b", 1'b1, L_B, R_B);
    @(negedge clk_in);
    data_in = 'x; data_in_valid = 1'b0;
    @(posedge clk_in); #1;
    chk("single_b_hold", 1'b0, L_B, R_B);

    // Single block C
    @(negedge clk_in);
    data_in = IN_C; data_in_valid = 1'b1;
    @(posedge clk_in); #1;
    chk("single_c", 1'b1, L_C, R_C);
    @(negedge clk_in);
    data_in = 'x; data_in_valid = 1'b0;
    @(posedge clk_in); #1;
    chk("single_c_hold", 1'b0, L_C, R_C);

    // Back-to-back A, B, C
    @(negedge clk_in);
    data_in = IN_A; data_in_valid = 1'b1;
    @(posedge clk_in); #1;
    chk("b2b_a", 1'b1, L_A, R_A);
    @(negedge clk_in);
    data_in = IN_B;
    @(posedge clk_in); #1;
    chk("b2b_b", 1'b1, L_B, R_B);
    @(negedge clk_in);
    data_in = IN_C;
    @(posedge clk_in); #1;
    chk("b2b_c", 1'b1, L_C, R_C);
    @(negedge clk_in);
    data_in = 'x; data_in_valid = 1'b0;
    @(posedge clk_in); #1;
    chk("b2b_hold1", 1'b0, L_C, R_C);
    @(posedge clk_in); #1;
    chk("b2b_hold2", 1'b0, L_C, R_C);

    // Mid-flight reset: block launched, reset lands before the sampling edge
    @(negedge clk_in);
    data_in = IN_A; data_in_valid = 1'b1;
    #2;
    rst_in = 1'b1;
    #1;
    chk("midrst_async_clear", 1'b0, 32'h0, 32'h0);
    @(posedge clk_in); #1;
    chk("midrst_no_strobe", 1'b0, 32'h0, 32'h0);

    // First edge after release samples normally
    @(negedge clk_in);
    rst_in = 1'b0;
    data_in = IN_B; data_in_valid = 1'b1;
    @(posedge clk_in); #1;
    chk("post_rst_block", 1'b1, L_B, R_B);
    @(negedge clk_in);
    data_in = 'x; data_in_valid = 1'b0;
    @(posedge clk_in); #1;
    chk("post_rst_hold", 1'b0, L_B, R_B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
